// File: rtl/pipe_ctrl_stages.sv
// pipe_ctrl_stages: carries decoded control through ID/EX, EX/MEM and MEM/WB, with load-use stall and MEM branch flush
module pipe_ctrl_stages #(
  parameter int REG_AW   = 5,
  parameter int ALUC_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [ALUC_W+9:0]   id_ctrl,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                ex_zero,
  output logic [ALUC_W+2:0]   ex_ctrl,
  output logic                mem_write,
  output logic                br_taken,
  output logic                flush,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic                wb_pc_to_reg,
  output logic [REG_AW-1:0]   wb_dest,
  output logic                pc_wre,
  output logic                ir_wre
);
  logic              exValid, exMemWrite, exMemToReg, exPcToReg, exRegWrite;
  logic [1:0]        exBranch;
  logic [REG_AW-1:0] exDest;
  logic              memValid, memZero, memMemToReg, memPcToReg, memRegWrite;
  logic [1:0]        memBranch;
  logic [REG_AW-1:0] memDest;
  logic [REG_AW-1:0] idDest;
  logic              stall, loadId, keepEx;

  // hazard detection, branch resolution and fetch enables
  always_comb begin
    idDest   = id_ctrl[1] ? REG_AW'(LINK_REG) : (id_ctrl[7] ? id_rd : id_rt);
    stall    = exValid & exMemToReg & exRegWrite & (exDest != '0) & id_valid &
               ((exDest == id_rs) | (exDest == id_rt));
    br_taken = memValid & ((memBranch == 2'b11) | ((memBranch == 2'b01) & memZero) |
               ((memBranch == 2'b10) & !memZero));
    flush    = br_taken;
    loadId   = id_valid & !stall & !br_taken;
    keepEx   = !br_taken;
    pc_wre   = !rst & (br_taken | !stall);
    ir_wre   = pc_wre;
  end

  // ID/EX: capture ID instruction, or a bubble on stall/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid    <= 1'b0;
      ex_ctrl    <= '0;
      exMemWrite <= 1'b0;
      exBranch   <= 2'b00;
      exMemToReg <= 1'b0;
      exPcToReg  <= 1'b0;
      exRegWrite <= 1'b0;
      exDest     <= '0;
    end else begin
      exValid    <= loadId;
      ex_ctrl    <= loadId ? {id_ctrl[ALUC_W+9:8], id_ctrl[6]} : '0;
      exMemWrite <= loadId & id_ctrl[5];
      exBranch   <= loadId ? id_ctrl[4:3] : 2'b00;
      exMemToReg <= loadId & id_ctrl[2];
      exPcToReg  <= loadId & id_ctrl[1];
      exRegWrite <= loadId & id_ctrl[0];
      exDest     <= loadId ? idDest : '0;
    end
  end

  // EX/MEM: advance EX instruction with its zero flag, bubble on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memValid    <= 1'b0;
      mem_write   <= 1'b0;
      memBranch   <= 2'b00;
      memZero     <= 1'b0;
      memMemToReg <= 1'b0;
      memPcToReg  <= 1'b0;
      memRegWrite <= 1'b0;
      memDest     <= '0;
    end else begin
      memValid    <= keepEx & exValid;
      mem_write   <= keepEx & exMemWrite;
      memBranch   <= keepEx ? exBranch : 2'b00;
      memZero     <= keepEx & exValid & ex_zero;
      memMemToReg <= keepEx & exMemToReg;
      memPcToReg  <= keepEx & exPcToReg;
      memRegWrite <= keepEx & exRegWrite;
      memDest     <= keepEx ? exDest : '0;
    end
  end

  // MEM/WB: always advances, the writeback instruction is never killed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_pc_to_reg  <= 1'b0;
      wb_dest       <= '0;
    end else begin
      wb_reg_write  <= memRegWrite;
      wb_mem_to_reg <= memMemToReg;
      wb_pc_to_reg  <= memPcToReg;
      wb_dest       <= memDest;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_stages.sv
// tb_pipe_ctrl_stages: directed vectors with a writeback scoreboard for pipe_ctrl_stages
module tb_pipe_ctrl_stages;
  localparam logic [14:0] C_R   = {5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
  localparam logic [14:0] C_LW  = {5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1};
  localparam logic [14:0] C_SW  = {5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] C_BEQ = {5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] C_BNE = {5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] C_J   = {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] C_JAL = {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1};
  localparam logic [14:0] C_SWJ = {5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, ex_zero = 1'b0;
  logic [14:0] id_ctrl = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [7:0] ex_ctrl;
  logic mem_write, br_taken, flush, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, pc_wre, ir_wre;
  logic [4:0] wb_dest;

  typedef struct {
    int         c;
    logic [4:0] d;
    logic       m;
    logic       p;
  } exp_t;
  exp_t sbq[$];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  pipe_ctrl_stages dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero), .ex_ctrl(ex_ctrl),
    .mem_write(mem_write), .br_taken(br_taken), .flush(flush),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_pc_to_reg(wb_pc_to_reg), .wb_dest(wb_dest), .pc_wre(pc_wre), .ir_wre(ir_wre)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic issue(input logic [14:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
    @(posedge clk);
    #1;
    id_valid = 1'b1;
    id_ctrl  = c;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
    ex_zero  = z;
  endtask

  task automatic idle(input logic z = 1'b0);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    id_ctrl  = '0;
    id_rs    = '0;
    id_rt    = '0;
    id_rd    = '0;
    ex_zero  = z;
  endtask

  task automatic push(input logic [4:0] d, input logic m, input logic p, input int lat);
    exp_t e;
    e.c = cyc + lat;
    e.d = d;
    e.m = m;
    e.p = p;
    sbq.push_back(e);
  endtask

  // writeback monitor: every register-file write must match the next expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst && wb_reg_write) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL wb_unexpected: got write dest %0d at cycle %0d, expected none", wb_dest, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.c != cyc || e.d !== wb_dest || e.m !== wb_mem_to_reg || e.p !== wb_pc_to_reg) begin
          nerr++;
          $display("FAIL wb_write: got cyc %0d dest %0d m2r %0b p2r %0b, expected cyc %0d dest %0d m2r %0b p2r %0b",
                   cyc, wb_dest, wb_mem_to_reg, wb_pc_to_reg, e.c, e.d, e.m, e.p);
        end
      end
    end
  end

  initial begin
    repeat (2) begin
      @(negedge clk);
      chk("rst_pc_wre", pc_wre, 0);
      chk("rst_ir_wre", ir_wre, 0);
    end
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_br_taken", br_taken, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_pc_wre", pc_wre, 1);
    chk("rel_ir_wre", ir_wre, 1);
    // back-to-back R-type
    issue(C_R, 1, 2, 5, 0); push(5, 0, 0, 3);
    @(negedge clk); chk("r5_pc_wre", pc_wre, 1);
    issue(C_R, 1, 2, 6, 0); push(6, 0, 0, 3);
    @(negedge clk); chk("r6_pc_wre", pc_wre, 1);
    issue(C_R, 1, 2, 7, 0); push(7, 0, 0, 3);
    @(negedge clk); chk("r7_pc_wre", pc_wre, 1);
    repeat (3) idle();
    // reset with instructions in flight
    issue(C_R, 1, 2, 9, 0); push(9, 0, 0, 3);
    issue(C_R, 1, 2, 10, 0);
    issue(C_SW, 3, 4, 0, 0);
    issue(C_R, 1, 2, 11, 0);
    idle();
    chk("pre_rst_wb_dest", wb_dest, 10);
    chk("pre_rst_mem_write", mem_write, 1);
    chk("pre_rst_ex_ctrl", ex_ctrl, 8'h10);
    rst = 1'b1;
    #1;
    chk("mid_rst_wb_reg_write", wb_reg_write, 0);
    chk("mid_rst_wb_dest", wb_dest, 0);
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_ex_ctrl", ex_ctrl, 0);
    chk("mid_rst_pc_wre", pc_wre, 0);
    chk("mid_rst_ir_wre", ir_wre, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); chk("rel2_pc_wre", pc_wre, 1);
    // load-use on rs, then on rt, then via r0
    issue(C_LW, 1, 8, 0, 0); push(8, 1, 0, 3);
    @(negedge clk); chk("lw_pc_wre", pc_wre, 1);
    issue(C_R, 8, 2, 12, 0); push(12, 0, 0, 4);
    @(negedge clk);
    chk("stall_pc_wre", pc_wre, 0);
    chk("stall_ir_wre", ir_wre, 0);
    chk("stall_ex_lw", ex_ctrl, 8'h13);
    issue(C_R, 8, 2, 12, 0);
    @(negedge clk);
    chk("post_stall_pc_wre", pc_wre, 1);
    chk("post_stall_ex_bubble", ex_ctrl, 0);
    issue(C_LW, 1, 14, 0, 0); push(14, 1, 0, 3);
    issue(C_R, 3, 14, 15, 0); push(15, 0, 0, 4);
    @(negedge clk); chk("stall_rt_pc_wre", pc_wre, 0);
    issue(C_R, 3, 14, 15, 0);
    @(negedge clk); chk("post_stall_rt_pc_wre", pc_wre, 1);
    issue(C_LW, 1, 0, 0, 0); push(0, 1, 0, 3);
    issue(C_R, 0, 0, 13, 0); push(13, 0, 0, 3);
    @(negedge clk); chk("r0_no_stall", pc_wre, 1);
    repeat (3) idle();
    // BEQ taken: two younger instructions squashed
    issue(C_BEQ, 1, 2, 0, 0);
    issue(C_R, 1, 2, 20, 1);
    issue(C_R, 1, 2, 21, 0);
    @(negedge clk);
    chk("beq_t_br_taken", br_taken, 1);
    chk("beq_t_flush", flush, 1);
    chk("beq_t_pc_wre", pc_wre, 1);
    issue(C_R, 1, 2, 22, 0); push(22, 0, 0, 3);
    @(negedge clk);
    chk("beq_t_after", br_taken, 0);
    chk("beq_t_ex_bubble", ex_ctrl, 0);
    // BEQ not taken
    issue(C_BEQ, 1, 2, 0, 0);
    issue(C_R, 1, 2, 23, 0); push(23, 0, 0, 3);
    issue(C_R, 1, 2, 24, 0); push(24, 0, 0, 3);
    @(negedge clk); chk("beq_nt_br_taken", br_taken, 0);
    // BNE taken
    issue(C_BNE, 1, 2, 0, 0);
    issue(C_R, 1, 2, 25, 0);
    issue(C_R, 1, 2, 26, 0);
    @(negedge clk); chk("bne_t_br_taken", br_taken, 1);
    issue(C_R, 1, 2, 27, 0); push(27, 0, 0, 3);
    // BNE not taken
    issue(C_BNE, 1, 2, 0, 0);
    issue(C_R, 1, 2, 17, 1); push(17, 0, 0, 3);
    issue(C_R, 1, 2, 18, 0); push(18, 0, 0, 3);
    @(negedge clk); chk("bne_nt_br_taken", br_taken, 0);
    // J always taken
    issue(C_J, 0, 0, 0, 0);
    issue(C_R, 1, 2, 28, 1);
    issue(C_R, 1, 2, 29, 0);
    @(negedge clk); chk("j_br_taken", br_taken, 1);
    issue(C_R, 1, 2, 30, 0); push(30, 0, 0, 3);
    // load-use in ID while taken branch in MEM: flush wins
    issue(C_BEQ, 1, 2, 0, 0);
    issue(C_LW, 1, 8, 0, 1);
    issue(C_R, 8, 2, 16, 0);
    @(negedge clk);
    chk("hz_flush", flush, 1);
    chk("hz_pc_wre", pc_wre, 1);
    chk("hz_ir_wre", ir_wre, 1);
    issue(C_R, 1, 2, 19, 0); push(19, 0, 0, 3);
    @(negedge clk); chk("hz_after_pc_wre", pc_wre, 1);
    // store carrying a taken branch field still writes memory
    issue(C_SWJ, 3, 4, 0, 0);
    issue(C_R, 1, 2, 3, 0);
    issue(C_R, 1, 2, 4, 0);
    @(negedge clk);
    chk("swj_mem_write", mem_write, 1);
    chk("swj_br_taken", br_taken, 1);
    // jal links to r31
    issue(C_JAL, 1, 4, 0, 0); push(31, 0, 1, 3);
    issue(C_R, 1, 2, 1, 0);
    issue(C_R, 1, 2, 2, 0);
    @(negedge clk); chk("jal_br_taken", br_taken, 1);
    repeat (5) idle();
    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
